// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package regfile_pkg;

    // Bulk-clear sequencer states.
    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    // Widest entry the parity helper covers; narrower data is zero-extended.
    localparam int PAR_MAX_W = 256;

    // Low bit of field idx in a flat bus of w-bit fields.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

    // Even-parity bit: data plus this bit always holds an even number of ones.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: walks every entry once, one entry per cycle.
// Latency: busy rises the cycle after clr_req and stays high NUM_REGISTERS cycles.
// Backpressure: clr_req is ignored while a clear runs; no stall input.
// Ports: clk, rst_n; clr_req in; busy, clr_done pulse, clr_addr/clr_we to the array.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS = 32,
    parameter int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGISTERS - 1);

    clr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_d = CLR_RUN;
                    cnt_d   = '0;
                end
            end
            CLR_RUN: begin
                // The last entry is zeroed on this edge; done pulses as busy drops.
                if (cnt_q == LAST_ADDR) begin
                    state_d = CLR_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    assign busy     = (state_q == CLR_RUN);
    assign clr_done = done_q;
    assign clr_addr = cnt_q;
    assign clr_we   = busy;

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-port register file with optional zero register, bypass and bulk clear.
// Latency: reads combinational (0 cycles); writes visible next cycle, or same cycle via bypass.
// Backpressure: while busy (bulk clear) all port writes are dropped; no stall signalling.
// Ports: ra/rd flat read buses, we/wa/wd flat write buses, clr_req in, busy/clr_done out,
//        rd_perr per read port only when REGFILE_PARITY_EN is defined.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int NUM_REGISTERS = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_RD        = 2,
    parameter int NUM_WR        = 1,
    parameter int ZERO_REG      = 1,
    parameter int BYPASS        = 1,
    parameter int ADDR_WIDTH    = $clog2(NUM_REGISTERS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd,
    input  logic [NUM_WR-1:0]            we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wa,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wd,
    input  logic                         clr_req,
    output logic                         busy,
    output logic                         clr_done
`ifdef REGFILE_PARITY_EN
    ,
    output logic [NUM_RD-1:0]            rd_perr
`endif
);

    logic [DATA_WIDTH-1:0] mem    [NUM_REGISTERS];
    logic                  wr_en  [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0] wr_dat [NUM_REGISTERS];
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;

    regfile_clear_fsm #(
        .NUM_REGISTERS (NUM_REGISTERS),
        .ADDR_WIDTH    (ADDR_WIDTH)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // Per-entry write select. The clear engine owns the array while it runs; otherwise
    // ports are scanned in index order so the highest matching port overrides the rest.
    // Out-of-range addresses match no entry and therefore write nothing.
    always_comb begin
        for (int e = 0; e < NUM_REGISTERS; e++) begin
            wr_en[e]  = 1'b0;
            wr_dat[e] = '0;
            if (clr_we) begin
                if (clr_addr == ADDR_WIDTH'(e)) wr_en[e] = 1'b1;
            end else begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && wa[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] == ADDR_WIDTH'(e)) begin
                        wr_en[e]  = 1'b1;
                        wr_dat[e] = wd[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end
            if (ZERO_REG != 0 && e == 0) wr_en[e] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_REGISTERS; e++) mem[e] <= '0;
        end else begin
            for (int e = 0; e < NUM_REGISTERS; e++) begin
                if (wr_en[e]) mem[e] <= wr_dat[e];
            end
        end
    end

`ifdef REGFILE_PARITY_EN
    // Clear writes carry zero data, so their parity bit comes out 0 as well.
    logic mem_par [NUM_REGISTERS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_REGISTERS; e++) mem_par[e] <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_REGISTERS; e++) begin
                if (wr_en[e]) mem_par[e] <= even_parity(PAR_MAX_W'(wr_dat[e]));
            end
        end
    end
`else
    // Without parity the array holds data bits only.
`endif

    // Read path: array lookup, then bypass from the winning write port, then the
    // zero-register and out-of-range rules, which override everything else.
    always_comb begin
        logic [ADDR_WIDTH-1:0] ra_i;
        logic [DATA_WIDTH-1:0] dat;
        logic                  hit;
        logic                  byp;
`ifdef REGFILE_PARITY_EN
        logic                  perr_i;
        rd_perr = '0;
`endif
        rd = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra_i = ra[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
            dat  = '0;
            hit  = 1'b0;
            byp  = 1'b0;
`ifdef REGFILE_PARITY_EN
            perr_i = 1'b0;
`endif
            for (int e = 0; e < NUM_REGISTERS; e++) begin
                if (ra_i == ADDR_WIDTH'(e)) begin
                    hit = 1'b1;
                    dat = mem[e];
`ifdef REGFILE_PARITY_EN
                    perr_i = mem_par[e] != even_parity(PAR_MAX_W'(mem[e]));
`endif
                end
            end
            if (BYPASS != 0 && !busy) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (we[j] && wa[slice_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] == ra_i) begin
                        byp = 1'b1;
                        dat = wd[slice_lo(j, DATA_WIDTH) +: DATA_WIDTH];
                    end
                end
            end
            if (!hit || (ZERO_REG != 0 && ra_i == '0)) begin
                dat = '0;
                byp = 1'b1;
            end
            rd[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = dat;
`ifdef REGFILE_PARITY_EN
            rd_perr[i] = perr_i && !byp;
`endif
        end
    end

endmodule
